imem_loader: RTL and testbench

- Writer side of the instruction memory. Receives a program as a byte stream and writes it into the byte-wide instruction store.
- Byte order is big-endian: the fetch path reads bytes addr, addr+1, addr+2, addr+3 as one word, most significant byte first.
- Holds the CPU (freezes PC update) for the whole load. Replaces the static file preload for reprogramming at run time.

---
 rtl/imem_loader_pkg.sv | 24 ++
 rtl/imem_loader_if.sv | 31 +++
 rtl/imem_loader_sum.sv | 29 ++
 rtl/imem_loader.sv | 176 +++++++++++++++++
 tb/tb_imem_loader.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding, stream
// field widths and the word-to-byte length conversion.
package imem_loader_pkg;

    localparam int LEN_W          = 16;
    localparam int BYTES_PER_WORD = 4;
    localparam int TOTAL_W        = LEN_W + 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN_HI,
        ST_LEN_LO,
        ST_DATA,
        ST_CHECK,
        ST_DONE,
        ST_ERROR
    } state_t;

    // Kept at full 18-bit width so a 16-bit word count can never overflow.
    function automatic logic [TOTAL_W-1:0] word_bytes(input logic [LEN_W-1:0] len);
        return TOTAL_W'(len) * TOTAL_W'(BYTES_PER_WORD);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-store write bundle of the loader.
// master = stream source / observer, slave = the loader itself.
interface imem_loader_if #(
    parameter int ADDR_W = 10
) ();

    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   byte_count;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata,
        input  cpu_hold, done, error, byte_count
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata,
        output cpu_hold, done, error, byte_count
    );

endinterface

// File: rtl/imem_loader_sum.sv
// 8-bit modular accumulator over the payload; sum_ok flags when adding the
// trailing checksum byte would bring the total to zero.
module imem_loader_sum (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       clear,
    input  logic       add,
    input  logic [7:0] add_data,
    input  logic [7:0] check_data,
    output logic       sum_ok
);

    logic [7:0] sum;
    logic [7:0] sum_with_check;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sum <= 8'h00;
        end else if (clear) begin
            sum <= 8'h00;
        end else if (add) begin
            sum <= sum + add_data;
        end
    end

    assign sum_with_check = sum + check_data;
    assign sum_ok         = (sum_with_check == 8'h00);

endmodule

// File: rtl/imem_loader.sv
// Run-time instruction-store loader: parses a length-prefixed byte stream,
// writes it big-endian into the byte store and holds the CPU meanwhile.
// Optional trailing checksum byte enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input logic          CLK,
    input logic          RST_N,
    imem_loader_if.slave bus
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam state_t AFTER_DATA = ST_CHECK;
`else
    localparam state_t AFTER_DATA = ST_DONE;
`endif

    state_t             state;
    state_t             next_state;
    logic [7:0]         len_hi;
    logic [TOTAL_W-1:0] total;
    logic [TOTAL_W-1:0] len_total;
    logic [ADDR_W:0]    byte_count;
    logic               in_ready;
    logic               accept;
    logic               start_ok;
    logic               last_beat;
    logic               data_beat;
    logic               enter_done;
    logic               enter_error;
    logic               mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [7:0]         mem_wdata;
    logic               cpu_hold;
    logic               done;
    logic               error;

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic sum_ok;

    imem_loader_sum u_sum (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .clear      (start_ok),
        .add        (data_beat),
        .add_data   (bus.in_data),
        .check_data (bus.in_data),
        .sum_ok     (sum_ok)
    );
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        start_ok   = 1'b0;
        len_total  = word_bytes({len_hi, bus.in_data});
        last_beat  = ((32'(byte_count) + 32'd1) == 32'(total));
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                start_ok = bus.start;
                if (bus.start) begin
                    next_state = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    next_state = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    if (32'(len_total) > MEM_LIMIT) begin
                        next_state = ST_ERROR;
                    end else if (len_total == '0) begin
                        next_state = AFTER_DATA;
                    end else begin
                        next_state = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                in_ready = 1'b1;
                if (bus.in_valid && last_beat) begin
                    next_state = AFTER_DATA;
                end
            end
            ST_CHECK: begin
                in_ready = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                if (bus.in_valid) begin
                    next_state = sum_ok ? ST_DONE : ST_ERROR;
                end
`else
                next_state = ST_ERROR;
`endif
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    assign accept      = in_ready && bus.in_valid;
    assign data_beat   = (state == ST_DATA) && accept;
    assign enter_done  = (next_state == ST_DONE)  && (state != ST_DONE);
    assign enter_error = (next_state == ST_ERROR) && (state != ST_ERROR);

    // Write register: each payload beat becomes a one-cycle store write on the
    // following cycle, so the last write coincides with cpu_hold falling.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            len_hi     <= 8'h00;
            total      <= '0;
            byte_count <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= 8'h00;
            cpu_hold   <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start_ok) begin
                done       <= 1'b0;
                error      <= 1'b0;
                byte_count <= '0;
                cpu_hold   <= 1'b1;
            end
            if ((state == ST_LEN_HI) && accept) begin
                len_hi <= bus.in_data;
            end
            if ((state == ST_LEN_LO) && accept) begin
                total <= len_total;
            end
            if (data_beat) begin
                mem_we     <= 1'b1;
                mem_addr   <= byte_count[ADDR_W-1:0];
                mem_wdata  <= bus.in_data;
                byte_count <= byte_count + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (enter_done) begin
                done     <= 1'b1;
                cpu_hold <= 1'b0;
            end
            if (enter_error) begin
                error    <= 1'b1;
                cpu_hold <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.mem_we     = mem_we;
    assign bus.mem_addr   = mem_addr;
    assign bus.mem_wdata  = mem_wdata;
    assign bus.cpu_hold   = cpu_hold;
    assign bus.done       = done;
    assign bus.error      = error;
    assign bus.byte_count = byte_count;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: expected store writes are queued as
// payload is driven and matched against each mem_we pulse.
module tb_imem_loader;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [7:0]        data;
    } wr_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    wr_t        sb[$];
    logic [7:0] payload[$];
    wr_t        seen;
    int         err_count   = 0;
    int         check_count = 0;
    int         write_count = 0;

    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(
        .MEM_BYTES (MEM_BYTES),
        .ADDR_W    (ADDR_W)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_count++;
        if (obs !== exp) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drives one byte and returns just after the edge that accepted it.
    task automatic applyStimulus(input logic [7:0] b, input bit stall);
        bit ok;
        ok = 1'b0;
        if (stall) begin
            repeat ($urandom_range(0, 3)) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
            end
        end
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = b;
            if (bus.in_ready === 1'b1) begin
                @(posedge clk);
                ok = 1'b1;
            end
        end
        if (!ok) checkOutput("ready_timeout", 0, 1);
    endtask

    task automatic send_load(input logic [15:0] len, input bit stall, input bit bad_ck);
        int         total;
        int         exp_bytes;
        int         w0;
        bit         exp_err;
        logic [7:0] b;
        logic [7:0] sum;
        wr_t        e;
        total     = int'(len) * 4;
        exp_err   = (total > MEM_BYTES);
        exp_bytes = exp_err ? 0 : total;
        w0        = write_count;
        sum       = 8'h00;
`ifdef IMEM_LOADER_CHECKSUM_EN
        exp_err = exp_err || bad_ck;
`endif
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("hold_after_start", bus.cpu_hold, 1);
        checkOutput("done_cleared", bus.done, 0);
        checkOutput("error_cleared", bus.error, 0);
        checkOutput("count_cleared", bus.byte_count, 0);
        checkOutput("ready_in_len", bus.in_ready, 1);
        applyStimulus(len[15:8], stall);
        applyStimulus(len[7:0], stall);
        if (total <= MEM_BYTES) begin
            for (int i = 0; i < total; i++) begin
                b = (i < payload.size()) ? payload[i] : 8'($urandom);
                e.addr = ADDR_W'(i);
                e.data = b;
                sb.push_back(e);
                sum = sum + b;
                applyStimulus(b, stall);
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            b = 8'h00 - sum;
            if (bad_ck) b = b + 8'h01;
            applyStimulus(b, stall);
`endif
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
`ifndef IMEM_LOADER_CHECKSUM_EN
        if (total > 0 && total <= MEM_BYTES)
            checkOutput("last_wr_at_hold_drop", {30'd0, bus.mem_we, bus.cpu_hold}, 2);
`endif
        checkOutput("done", bus.done, !exp_err);
        checkOutput("error", bus.error, exp_err);
        checkOutput("hold_released", bus.cpu_hold, 0);
        checkOutput("ready_after", bus.in_ready, 0);
        checkOutput("byte_count", bus.byte_count, exp_bytes);
        @(negedge clk);
        checkOutput("write_count", write_count - w0, exp_bytes);
        checkOutput("sb_empty", sb.size(), 0);
        checkOutput("flag_sticky", {30'd0, bus.done, bus.error}, {30'd0, !exp_err, exp_err});
        payload.delete();
    endtask

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            write_count++;
            if (sb.size() == 0) begin
                checkOutput("unexpected_write", 1, 0);
            end else begin
                seen = sb.pop_front();
                checkOutput("wr_addr", bus.mem_addr, seen.addr);
                checkOutput("wr_data", bus.mem_wdata, seen.data);
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        wr_t e;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst_n        = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_in_ready", bus.in_ready, 0);
        checkOutput("rst_cpu_hold", bus.cpu_hold, 0);
        checkOutput("rst_done", bus.done, 0);
        checkOutput("rst_error", bus.error, 0);
        checkOutput("rst_mem_we", bus.mem_we, 0);
        checkOutput("rst_byte_count", bus.byte_count, 0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("idle_in_ready", bus.in_ready, 0);

        $display("[TB] one-word load");
        payload = '{8'h8C, 8'h22, 8'h00, 8'h00};
        send_load(16'h0001, 1'b0, 1'b0);

        $display("[TB] oversized length");
        send_load(16'h0101, 1'b0, 1'b0);

        $display("[TB] zero length");
        send_load(16'h0000, 1'b0, 1'b0);

        $display("[TB] two words with random stalls");
        send_load(16'h0002, 1'b1, 1'b0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        $display("[TB] bad checksum then good reload");
        payload = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_load(16'h0001, 1'b0, 1'b1);
        payload = '{8'h12, 8'h34, 8'h56, 8'h78};
        send_load(16'h0001, 1'b0, 1'b0);
`endif

        $display("[TB] reset during payload");
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        applyStimulus(8'h00, 1'b0);
        applyStimulus(8'h02, 1'b0);
        for (int i = 0; i < 2; i++) begin
            e.addr = ADDR_W'(i);
            e.data = 8'hA0 + 8'(i);
            sb.push_back(e);
            applyStimulus(e.data, 1'b0);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid_rst_hold", bus.cpu_hold, 0);
        checkOutput("mid_rst_we", bus.mem_we, 0);
        checkOutput("mid_rst_ready", bus.in_ready, 0);
        checkOutput("mid_rst_count", bus.byte_count, 0);
        checkOutput("mid_rst_addr", bus.mem_addr, 0);
        checkOutput("mid_rst_wdata", bus.mem_wdata, 0);
        checkOutput("mid_rst_flags", {30'd0, bus.done, bus.error}, 0);
        checkOutput("mid_rst_sb", sb.size(), 0);
        @(negedge clk);
        rst_n = 1'b1;
        payload = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
        send_load(16'h0001, 1'b0, 1'b0);

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
